// File: rtl/led_seq_pkg.sv
// Shared types for the LED sequencer: pattern mode encoding and sweep direction.
package led_seq_pkg;

  typedef enum logic [1:0] {
    MODE_COUNT   = 2'd0,
    MODE_SCAN    = 2'd1,
    MODE_BLINK   = 2'd2,
    MODE_BREATHE = 2'd3
  } mode_e;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_e;

endpackage

// File: rtl/tick_divider.sv
// Programmable prescaler: one-cycle tick every div+1 enabled clk50 cycles.
module tick_divider
  import led_seq_pkg::*;
#(
  parameter int unsigned DIV_WIDTH = 32
) (
  input  logic                 clk50,
  input  logic                 rst,
  input  logic                 enable,
  input  logic [DIV_WIDTH-1:0] div,
  output logic                 tick
);

  logic [DIV_WIDTH-1:0] count_q, count_d;
  logic                 tick_q, tick_d;

  // >= rather than == so a div lowered below the running count wraps at once.
  always_comb begin
    count_d = count_q;
    tick_d  = 1'b0;
    if (enable) begin
      if (count_q >= div) begin
        count_d = '0;
        tick_d  = 1'b1;
      end else begin
        count_d = count_q + DIV_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk50) begin
    if (rst) begin
      count_q <= '0;
      tick_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      tick_q  <= tick_d;
    end
  end

  assign tick = tick_q;

endmodule

// File: rtl/led_sequencer.sv
// LED pattern engine: four tick-driven modes, mode request handshake and a
// heartbeat that toggles each time the frame counter wraps.
module led_sequencer
  import led_seq_pkg::*;
#(
  parameter int unsigned CH        = 6,
  parameter int unsigned DIV_WIDTH = 32,
  parameter int unsigned PWM_BITS  = 4
) (
  input  logic                 clk50,
  input  logic                 rst,
  input  logic [DIV_WIDTH-1:0] div,
  input  logic                 enable,
  input  logic [1:0]           mode,
  input  logic                 mode_valid,
  output logic                 mode_ready,
  output logic                 tick,
  output logic [CH-1:0]        leds,
  output logic                 blink
);

  localparam int unsigned POS_W = (CH > 1) ? $clog2(CH) : 1;

  logic [PWM_BITS-1:0] lvl_max;
  assign lvl_max = '1;

  mode_e               mode_q, mode_d;
  mode_e               pend_q, pend_d;
  logic                ready_q, ready_d;
  logic [CH-1:0]       frame_q, frame_d;
  logic                blink_q, blink_d;
  logic [CH-1:0]       leds_q, leds_d;
  logic [POS_W-1:0]    pos_q, pos_d;
  dir_e                sdir_q, sdir_d;
  logic [PWM_BITS-1:0] level_q, level_d;
  dir_e                ldir_q, ldir_d;
  logic [PWM_BITS-1:0] pwm_q, pwm_d;
  logic                switch_c;

  tick_divider #(
    .DIV_WIDTH(DIV_WIDTH)
  ) u_tick_divider (
    .clk50 (clk50),
    .rst   (rst),
    .enable(enable),
    .div   (div),
    .tick  (tick)
  );

  always_comb begin
    mode_d   = mode_q;
    pend_d   = pend_q;
    ready_d  = ready_q;
    frame_d  = frame_q;
    blink_d  = blink_q;
    leds_d   = leds_q;
    pos_d    = pos_q;
    sdir_d   = sdir_q;
    level_d  = level_q;
    ldir_d   = ldir_q;
    pwm_d    = pwm_q + PWM_BITS'(1);
    // A pending request only exists once ready has dropped, so a request
    // accepted in a tick cycle waits for the following tick.
    switch_c = tick && !ready_q;

    if (mode_valid && ready_q) begin
      pend_d  = mode_e'(mode);
      ready_d = 1'b0;
    end

    if (tick) begin
      frame_d = frame_q + CH'(1);
      if (&frame_q) begin
        blink_d = ~blink_q;
      end

      if (switch_c) begin
        mode_d  = pend_q;
        ready_d = 1'b1;
        pos_d   = '0;
        sdir_d  = DIR_UP;
        level_d = '0;
        ldir_d  = DIR_UP;
        case (pend_q)
          MODE_COUNT: leds_d = frame_d;
          MODE_SCAN:  leds_d = CH'(1);
          MODE_BLINK: leds_d = '1;
          default:    leds_d = '0;
        endcase
      end else begin
        case (mode_q)
          MODE_COUNT: leds_d = frame_d;
          MODE_SCAN: begin
            if (CH > 1) begin
              if (sdir_q == DIR_UP) begin
                if (pos_q == POS_W'(CH - 1)) begin
                  pos_d  = pos_q - POS_W'(1);
                  sdir_d = DIR_DOWN;
                end else begin
                  pos_d = pos_q + POS_W'(1);
                end
              end else begin
                if (pos_q == '0) begin
                  pos_d  = pos_q + POS_W'(1);
                  sdir_d = DIR_UP;
                end else begin
                  pos_d = pos_q - POS_W'(1);
                end
              end
            end
            leds_d = CH'(1) << pos_d;
          end
          MODE_BLINK: leds_d = ~leds_q;
          default: begin
            if (ldir_q == DIR_UP) begin
              if (level_q == lvl_max) begin
                level_d = level_q - PWM_BITS'(1);
                ldir_d  = DIR_DOWN;
              end else begin
                level_d = level_q + PWM_BITS'(1);
              end
            end else begin
              if (level_q == '0) begin
                level_d = level_q + PWM_BITS'(1);
                ldir_d  = DIR_UP;
              end else begin
                level_d = level_q - PWM_BITS'(1);
              end
            end
          end
        endcase
      end
    end

    // Breathe output is a PWM compare refreshed every cycle, not only on ticks.
    if (mode_d == MODE_BREATHE) begin
      leds_d = {CH{pwm_q < level_d}};
    end
  end

  always_ff @(posedge clk50) begin
    if (rst) begin
      mode_q  <= MODE_COUNT;
      pend_q  <= MODE_COUNT;
      ready_q <= 1'b1;
      frame_q <= '0;
      blink_q <= 1'b0;
      leds_q  <= '0;
      pos_q   <= '0;
      sdir_q  <= DIR_UP;
      level_q <= '0;
      ldir_q  <= DIR_UP;
      pwm_q   <= '0;
    end else begin
      mode_q  <= mode_d;
      pend_q  <= pend_d;
      ready_q <= ready_d;
      frame_q <= frame_d;
      blink_q <= blink_d;
      leds_q  <= leds_d;
      pos_q   <= pos_d;
      sdir_q  <= sdir_d;
      level_q <= level_d;
      ldir_q  <= ldir_d;
      pwm_q   <= pwm_d;
    end
  end

  assign mode_ready = ready_q;
  assign leds       = leds_q;
  assign blink      = blink_q;

endmodule

// File: doc/led_sequencer.md
Name: led_sequencer

Overview:
- Parametrised successor to the board's free-running LED counter/heartbeat.
- A programmable prescaler generates a tick. On each tick, a CH-wide LED pattern engine advances in one of four runtime-selectable modes:
  - binary count
  - bounce scan
  - blink-all
  - PWM breathe
- A heartbeat output toggles on every pattern frame wrap.
- Sits at the top level, driving the on-board LEDs and the blink pin from clk50.

Parameters:
- CH, 6: number of LED channels (>=1).
- DIV_WIDTH, 32: width of the prescaler divide value.
- PWM_BITS, 4: breathe-mode duty resolution.

Ports:
- clk50  in  1  system clock. One clock; reset is synchronous and active-high.
- rst  in  1  synchronous active-high reset.
- div  in  DIV_WIDTH  tick period minus 1, in clk50 cycles.
- enable  in  1  prescaler run; low freezes the prescaler and the pattern.
- mode  in  2  requested pattern mode.
- mode_valid  in  1  mode request strobe.
- mode_ready  out  1  high when a new mode request can be accepted.
- tick  out  1  one-cycle pulse per pattern step.
- leds  out  CH  LED drive, registered.
- blink  out  1  heartbeat, registered.

Behaviour:
- Reset values (rst sampled high on a clk50 edge):
  - prescaler count = 0, tick = 0
  - current mode = COUNT (0), no pending request, mode_ready = 1
  - leds = 0, blink = 0, frame = 0
  - scan position 0 with direction up, breathe level 0 with direction up, pwm counter 0
- rst overrides all other inputs. An in-flight mode request is discarded.
- Prescaler:
  - While enable = 1: if count >= div, then tick <= 1 and count <= 0; else count++ and tick <= 0.
  - div = 0 gives a tick every cycle.
  - Lowering div below the current count wraps on the next cycle.
  - While enable = 0: count holds and tick <= 0.
- Pattern registers update in the cycle tick is high, so leds reflect the new step one cycle after tick.
- frame:
  - CH-bit counter, increments on every tick in all modes.
  - On the all-ones -> 0 wrap, blink toggles.
  - Mode changes do not touch frame or blink.
- Mode handshake:
  - A request is accepted when mode_valid && mode_ready. The mode is captured into pending and mode_ready <= 0.
  - On the next tick strictly after acceptance, current mode <= pending and the new mode's pattern state is loaded with its start value, which appears on leds one cycle later.
  - mode_ready returns to 1 in the cycle after that tick.
  - If acceptance and tick occur in the same cycle, the request applies on the following tick.
  - mode_valid while mode_ready = 0 is ignored.
  - Requesting the current mode still restarts its pattern.
- Mode COUNT (0): leds = frame value.
  - Start value: leds takes the current frame value (frame is not reset). leds follows frame on every tick.
- Mode SCAN (1): one-hot position.
  - Start value: position 0, direction up.
  - Sequence: 0, 1, ..., CH-1, CH-2, ..., 0, 1, ...
  - Direction flips at both ends, with no repeated end positions.
  - CH = 1: leds stays 1.
- Mode BLINK (2): all LEDs equal.
  - Start value: all ones.
  - Inverts on every tick.
- Mode BREATHE (3):
  - Level steps through 0 .. 2^PWM_BITS-1, ramping up then down without repeating the ends.
  - Start value: level 0, direction up.
  - A PWM_BITS-wide pwm counter free-runs every clk50 cycle, independent of enable.
  - All leds = (pwm counter < level). Level 0 is fully off; maximum level is on for (2^PWM_BITS-1)/2^PWM_BITS of cycles.
- Boundaries:
  - frame wrap and a mode switch in the same tick: both take effect.
  - enable low with a request pending: the request stays pending, mode_ready stays 0.

Decomposition:
- Package led_seq_pkg holds:
  - mode encoding: MODE_COUNT = 0, MODE_SCAN = 1, MODE_BLINK = 2, MODE_BREATHE = 3
  - the mode typedef
  - SCAN direction constants
- One sub-module, tick_divider: the prescaler with enable and div producing tick.
- The pattern engine and handshake stay in led_sequencer.

Test Plan:
- Reset/count: rst for 2 cycles, div = 3, enable = 1, mode untouched -> tick every 4 cycles. leds reads 0, 1, 2, ..., 63, 0. blink 0 -> 1 on the 64th tick.
- Divider edge: div = 0 -> tick every cycle. Change div from 9 to 2 while count = 7 -> tick on the next cycle, then every 3 cycles. enable = 0 for 10 cycles -> no ticks, leds frozen.
- Scan: CH = 6, request SCAN while idle -> mode_ready falls. At the next tick leds = 000001, then 000010, ..., 100000, 010000, ..., 000001. mode_ready rises one cycle after the switch tick.
- Handshake collision: assert mode_valid (BLINK) in the same cycle as tick -> mode unchanged at that tick, switches at the next tick (leds = 111111, then 000000). A second mode_valid while mode_ready = 0 -> ignored.
- Breathe: PWM_BITS = 4, div = 63, BREATHE -> duty measured over 16 cycles is 0, 1, ..., 15, 14, ..., 0 sixteenths per successive tick.
- Mid-operation reset: assert rst during SCAN at position 3 with a request pending -> next cycle leds = 0, mode COUNT, mode_ready = 1, blink = 0, pending discarded.
